// File: rtl/mem_ring_station_pkg.sv
// Shared ring definitions: slot-type codes, address-word layout and station FSM states.
package mem_ring_station_pkg;

  typedef enum logic [3:0] {
    SlotNull   = 4'd0,
    SlotToken  = 4'd1,
    SlotAddr   = 4'd2,
    SlotWrData = 4'd3
  } slot_type_e;

  localparam int unsigned AddrWidth   = 26;
  localparam int unsigned AddrLsb     = 0;
  localparam int unsigned AddrReadBit = 28;

  typedef enum logic [2:0] {
    StIdle,
    StWaitToken,
    StSendAddr,
    StSendData,
    StRelease
  } state_e;

  // Address slot payload: read flag at bit 28, line address in the low bits, rest zero.
  function automatic logic [31:0] make_addr_word(input logic rd, input logic [AddrWidth-1:0] addr);
    logic [31:0] w;
    w = '0;
    w[AddrLsb +: AddrWidth] = addr;
    w[AddrReadBit] = rd;
    return w;
  endfunction

endpackage

// File: rtl/mem_ring_station_rd_return_catcher.sv
// Collects read-return words addressed to this station and tracks the outstanding read.
module rd_return_catcher
  import mem_ring_station_pkg::*;
#(
  parameter logic [3:0]  MY_ID  = 4'd1,
  parameter int unsigned NWORDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        set_pending_i,
  input  logic [31:0] rd_return_i,
  input  logic [3:0]  rd_dest_i,
  output logic        read_pending_o,
  output logic [31:0] rd_word_o,
  output logic        rd_word_valid_o,
  output logic        read_done_o
);

  localparam int unsigned CntW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

  logic            pending_q, pending_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     word_q, word_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (pending_q && (rd_dest_i == MY_ID)) begin
      word_d  = rd_return_i;
      valid_d = 1'b1;
      if (cnt_q == LastCnt) begin
        cnt_d     = '0;
        done_d    = 1'b1;
        pending_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (set_pending_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q <= 1'b0;
      cnt_q     <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign read_pending_o  = pending_q;
  assign rd_word_o       = word_q;
  assign rd_word_valid_o = valid_q;
  assign read_done_o     = done_q;

endmodule

// File: rtl/mem_ring_station.sv
// Token-ring memory station: waits for the token, sends an address (and write burst),
// releases the token, and collects read returns from the memory controller.
module mem_ring_station
  import mem_ring_station_pkg::*;
#(
  parameter logic [3:0]  MY_ID  = 4'd1,
  parameter int unsigned NWORDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_read_i,
  input  logic [25:0] req_addr_i,
  output logic        wd_pop_o,
  input  logic [31:0] wd_word_i,
  input  logic [31:0] ring_in_i,
  input  logic [3:0]  slot_type_in_i,
  input  logic [3:0]  source_in_i,
  output logic [31:0] ring_out_o,
  output logic [3:0]  slot_type_out_o,
  output logic [3:0]  source_out_o,
  input  logic [31:0] rd_return_i,
  input  logic [3:0]  rd_dest_i,
  output logic [31:0] rd_word_o,
  output logic        rd_word_valid_o,
  output logic        read_done_o,
  output logic        busy_o
);

  localparam int unsigned CntW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_q, rd_d;
  logic [25:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [3:0]      type_q, type_d;
  logic [3:0]      src_q, src_d;

  logic [31:0] filt_data;
  logic [3:0]  filt_type, filt_src;
  logic        slot_free, wd_pop, set_pending, req_ready, read_pending;

  always_comb begin
    filt_data = ring_in_i;
    filt_type = slot_type_in_i;
    filt_src  = source_in_i;
    // Our own message has gone all the way round; drop it.
    if (source_in_i == MY_ID) begin
      filt_data = '0;
      filt_type = SlotNull;
      filt_src  = '0;
    end
    slot_free = (filt_type == SlotNull);

    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    data_d      = filt_data;
    type_d      = filt_type;
    src_d       = filt_src;
    wd_pop      = 1'b0;
    set_pending = 1'b0;
    req_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        req_ready = ~read_pending;
        if (req_valid_i && req_ready) begin
          rd_d    = req_read_i;
          addr_d  = req_addr_i;
          state_d = StWaitToken;
        end
      end
      StWaitToken: begin
        if (filt_type == SlotToken) begin
          data_d  = '0;
          type_d  = SlotNull;
          src_d   = '0;
          state_d = StSendAddr;
        end
      end
      StSendAddr: begin
        if (slot_free) begin
          data_d = make_addr_word(rd_q, addr_q);
          type_d = SlotAddr;
          src_d  = MY_ID;
          if (rd_q) begin
            set_pending = 1'b1;
            state_d     = StRelease;
          end else begin
            state_d = StSendData;
          end
        end
      end
      StSendData: begin
        if (slot_free) begin
          data_d = wd_word_i;
          type_d = SlotWrData;
          src_d  = MY_ID;
          wd_pop = 1'b1;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = StRelease;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRelease: begin
        if (slot_free) begin
          data_d  = '0;
          type_d  = SlotToken;
          src_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      type_q  <= SlotNull;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      type_q  <= type_d;
      src_q   <= src_d;
    end
  end

  rd_return_catcher #(
    .MY_ID  (MY_ID),
    .NWORDS (NWORDS)
  ) u_catcher (
    .clock           (clock),
    .reset           (reset),
    .set_pending_i   (set_pending),
    .rd_return_i     (rd_return_i),
    .rd_dest_i       (rd_dest_i),
    .read_pending_o  (read_pending),
    .rd_word_o       (rd_word_o),
    .rd_word_valid_o (rd_word_valid_o),
    .read_done_o     (read_done_o)
  );

  // No write word is consumed while the burst is being abandoned by reset.
  assign wd_pop_o        = wd_pop & ~reset;
  assign req_ready_o     = req_ready;
  assign ring_out_o      = data_q;
  assign slot_type_out_o = type_q;
  assign source_out_o    = src_q;
  assign busy_o          = (state_q != StIdle) | read_pending;

endmodule

// File: tb/tb_mem_ring_station.sv
// Self-checking bench for mem_ring_station: slot-filter vector table plus write, read,
// foreign-slot stall and mid-burst reset sequences, checked through an expected-slot queue.
module tb_mem_ring_station;
  import mem_ring_station_pkg::*;

  localparam logic [3:0] MyId = 4'd1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_read;
  logic [25:0] req_addr;
  logic        wd_pop;
  logic [31:0] wd_word;
  logic [31:0] ring_in, ring_out;
  logic [3:0]  slot_type_in, slot_type_out, source_in, source_out;
  logic [31:0] rd_return, rd_word;
  logic [3:0]  rd_dest;
  logic        rd_word_valid, read_done, busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  t;
    logic [3:0]  s;
    logic [31:0] d;
  } slot_t;

  typedef struct {
    logic [3:0]  ti;
    logic [3:0]  si;
    logic [31:0] di;
    logic [3:0]  te;
    logic [3:0]  se;
    logic [31:0] de;
  } vec_t;

  slot_t exp_q[$];
  logic [32:0] rd_exp_q[$];
  vec_t vecs[6];

  mem_ring_station #(
    .MY_ID  (MyId),
    .NWORDS (8)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_read_i      (req_read),
    .req_addr_i      (req_addr),
    .wd_pop_o        (wd_pop),
    .wd_word_i       (wd_word),
    .ring_in_i       (ring_in),
    .slot_type_in_i  (slot_type_in),
    .source_in_i     (source_in),
    .ring_out_o      (ring_out),
    .slot_type_out_o (slot_type_out),
    .source_out_o    (source_out),
    .rd_return_i     (rd_return),
    .rd_dest_i       (rd_dest),
    .rd_word_o       (rd_word),
    .rd_word_valid_o (rd_word_valid),
    .read_done_o     (read_done),
    .busy_o          (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One ring cycle: drive a slot, queue the expected output slot, check pop, then the output.
  task automatic cyc(input logic [3:0] ti, input logic [3:0] si, input logic [31:0] di,
                     input logic [3:0] te, input logic [3:0] se, input logic [31:0] de,
                     input logic pop_e, input string name);
    slot_t e;
    slot_type_in = ti;
    source_in    = si;
    ring_in      = di;
    exp_q.push_back('{t: te, s: se, d: de});
    #1;
    chk({name, " wdPop"}, {31'd0, wd_pop}, {31'd0, pop_e});
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    chk({name, " type"}, {28'd0, slot_type_out}, {28'd0, e.t});
    chk({name, " src"}, {28'd0, source_out}, {28'd0, e.s});
    chk({name, " data"}, ring_out, e.d);
  endtask

  task automatic nul(input string name);
    cyc(SlotNull, 4'd0, 32'd0, SlotNull, 4'd0, 32'd0, 1'b0, name);
  endtask

  initial begin
    vecs[0] = '{SlotNull,   4'd0, 32'h0,        SlotNull,   4'd0, 32'h0};
    vecs[1] = '{SlotToken,  4'd0, 32'h0,        SlotToken,  4'd0, 32'h0};
    vecs[2] = '{SlotAddr,   4'd2, 32'hDEADBEEF, SlotAddr,   4'd2, 32'hDEADBEEF};
    vecs[3] = '{SlotWrData, MyId, 32'h11112222, SlotNull,   4'd0, 32'h0};
    vecs[4] = '{SlotToken,  MyId, 32'h0,        SlotNull,   4'd0, 32'h0};
    vecs[5] = '{SlotWrData, 4'd7, 32'h12345678, SlotWrData, 4'd7, 32'h12345678};

    reset = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_addr = '0; wd_word = '0;
    ring_in = 32'h5555AAAA; slot_type_in = SlotToken; source_in = 4'd3;
    rd_return = '0; rd_dest = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset type", {28'd0, slot_type_out}, {28'd0, SlotNull});
    chk("reset data", ring_out, 32'd0);
    chk("reset src", {28'd0, source_out}, 32'd0);
    chk("reset rdvalid/done/pop", {29'd0, rd_word_valid, read_done, wd_pop}, 32'd0);
    reset = 1'b0;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset reqReady", {31'd0, req_ready}, 32'd1);

    // Filtering and pass-through while idle
    for (int i = 0; i < 6; i++) begin
      cyc(vecs[i].ti, vecs[i].si, vecs[i].di, vecs[i].te, vecs[i].se, vecs[i].de, 1'b0,
          $sformatf("vec%0d", i));
    end

    // Write burst with a foreign Address slot in the middle
    req_valid = 1'b1; req_read = 1'b0; req_addr = 26'h0001234;
    #1;
    chk("wr reqReady", {31'd0, req_ready}, 32'd1);
    nul("wr accept");
    req_valid = 1'b0;
    chk("wr busy", {31'd0, busy}, 32'd1);
    nul("wr wait1");
    nul("wr wait2");
    cyc(SlotToken, 4'd0, 32'd0, SlotNull, 4'd0, 32'd0, 1'b0, "wr token");
    cyc(SlotNull, 4'd0, 32'd0, SlotAddr, MyId, 32'h00001234, 1'b0, "wr addr");
    begin
      int w;
      w = 0;
      for (int k = 0; k < 9; k++) begin
        if (k == 3) begin
          cyc(SlotAddr, 4'd2, 32'h0BADF00D, SlotAddr, 4'd2, 32'h0BADF00D, 1'b0, "wr foreign");
        end else begin
          wd_word = 32'hA0000000 + w;
          cyc(SlotNull, 4'd0, 32'd0, SlotWrData, MyId, 32'hA0000000 + w, 1'b1,
              $sformatf("wr word%0d", w));
          w++;
        end
      end
    end
    cyc(SlotNull, 4'd0, 32'd0, SlotToken, 4'd0, 32'd0, 1'b0, "wr release");
    chk("wr end busy", {31'd0, busy}, 32'd0);

    // Read request and its return burst
    req_valid = 1'b1; req_read = 1'b1; req_addr = 26'h3FFFFFF;
    nul("rd accept");
    req_valid = 1'b0;
    cyc(SlotToken, 4'd0, 32'd0, SlotNull, 4'd0, 32'd0, 1'b0, "rd token");
    cyc(SlotNull, 4'd0, 32'd0, SlotAddr, MyId, 32'h13FFFFFF, 1'b0, "rd addr");
    cyc(SlotNull, 4'd0, 32'd0, SlotToken, 4'd0, 32'd0, 1'b0, "rd release");
    req_valid = 1'b1; req_read = 1'b0; req_addr = 26'h0000042;
    #1;
    chk("rd pending reqReady", {31'd0, req_ready}, 32'd0);
    chk("rd pending busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      logic [32:0] e;
      if (i == 4) begin
        rd_dest = 4'd0;
        nul("rd gap");
        chk("rd gap valid", {31'd0, rd_word_valid}, 32'd0);
        chk("rd gap reqReady", {31'd0, req_ready}, 32'd0);
      end
      if (i == 7) req_valid = 1'b0;
      rd_dest = MyId;
      rd_return = 32'hC0DE0000 + i;
      rd_exp_q.push_back({(i == 7), 32'hC0DE0000 + i});
      nul($sformatf("rd ret%0d", i));
      chk($sformatf("rd ret%0d valid", i), {31'd0, rd_word_valid}, 32'd1);
      e = rd_exp_q.pop_front();
      chk($sformatf("rd ret%0d word", i), rd_word, e[31:0]);
      chk($sformatf("rd ret%0d done", i), {31'd0, read_done}, {31'd0, e[32]});
    end
    rd_dest = 4'd0;
    chk("rd after reqReady", {31'd0, req_ready}, 32'd1);
    chk("rd after busy", {31'd0, busy}, 32'd0);

    // Return addressed to us with nothing outstanding
    rd_dest = MyId; rd_return = 32'hFFFF0000;
    nul("stray ret");
    chk("stray valid", {31'd0, rd_word_valid}, 32'd0);
    rd_dest = 4'd0;
    nul("stray after");
    chk("stray after valid", {31'd0, rd_word_valid}, 32'd0);

    // Reset in the middle of a write burst
    req_valid = 1'b1; req_read = 1'b0; req_addr = 26'h0000055;
    nul("rst accept");
    req_valid = 1'b0;
    cyc(SlotToken, 4'd0, 32'd0, SlotNull, 4'd0, 32'd0, 1'b0, "rst token");
    cyc(SlotNull, 4'd0, 32'd0, SlotAddr, MyId, 32'h00000055, 1'b0, "rst addr");
    for (int w = 0; w < 4; w++) begin
      wd_word = 32'hB0000000 + w;
      cyc(SlotNull, 4'd0, 32'd0, SlotWrData, MyId, 32'hB0000000 + w, 1'b1,
          $sformatf("rst word%0d", w));
    end
    reset = 1'b1;
    wd_word = 32'hB0000004;
    slot_type_in = SlotToken; source_in = 4'd0; ring_in = 32'd0;
    #1;
    chk("rst wdPop", {31'd0, wd_pop}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("rst type", {28'd0, slot_type_out}, {28'd0, SlotNull});
    chk("rst data", ring_out, 32'd0);
    chk("rst reqReady", {31'd0, req_ready}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    nul("post rst");
    cyc(SlotToken, 4'd0, 32'd0, SlotToken, 4'd0, 32'd0, 1'b0, "post rst token fwd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ring_station.md
MEM_RING_STATION -- requirements
Module: mem_ring_station

Interface
REQ-001 Parameter MY_ID, default 4'd1, SHALL be this station's ring source ID; 0 is reserved for the memory controller.
REQ-002 Parameter NWORDS, default 8, SHALL be the number of 32-bit words per write burst and per read return.
REQ-003 The block SHALL have these ports: clock, reset, synchronous, active-high; clock clock.
REQ-004 clock  in  1  system clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 reqValid/reqReady  in/out  1/1  core request handshake.
REQ-007 reqRead  in  1  1 = read, 0 = write.
REQ-008 reqAddr  in  26  line address.
REQ-009 wdPop/wdWord  out/in  1/32  write-data pull: wdWord is presented combinationally and consumed on a cycle with wdPop=1.
REQ-010 RingIn/SlotTypeIn/SourceIn  in  32/4/4  upstream ring slot.
REQ-011 RingOut/SlotTypeOut/SourceOut  out  32/4/4  registered downstream ring slot.
REQ-012 RDreturn/RDdest  in  32/4  read-return path from the memory controller; RDdest=0 means idle.
REQ-013 rdWord/rdWordValid/readDone  out  32/1/1  returned read word, its qualifier, and a last-word pulse.
REQ-014 busy  out  1  high whenever a request is accepted but not yet finished.

Function
REQ-015 Ring outputs SHALL be registered, with 1-cycle latency from the ring inputs.
REQ-016 Slot filtering: any slot with SourceIn==MY_ID (own message returning) SHALL be emitted as Null/0/0; any other slot SHALL pass unchanged unless the FSM replaces it.
REQ-017 The FSM SHALL have exactly these states: IDLE, WAIT_TOKEN, SEND_ADDR, SEND_DATA, RELEASE.
REQ-018 reqReady SHALL be 1 only in IDLE with readPending=0; on reqValid&reqReady the block SHALL latch reqRead and reqAddr and move to WAIT_TOKEN.
REQ-019 Token handling in WAIT_TOKEN: a Token slot SHALL be consumed (emitted as Null) and the FSM SHALL go to SEND_ADDR; in all other states a Token SHALL pass through.
REQ-020 Insertion rule: the FSM SHALL insert only into a slot that is Null after filtering; a non-null slot SHALL pass through and stall the FSM for that cycle.
REQ-021 SEND_ADDR SHALL emit an Address slot with SourceOut=MY_ID and data {3'b000, reqRead, 2'b00, addr}; bit31 SHALL always be 0.
REQ-022 From SEND_ADDR, a write SHALL go to SEND_DATA; a read SHALL set readPending and go to RELEASE.
REQ-023 SEND_DATA SHALL emit NWORDS WriteData slots (SourceOut=MY_ID, data=wdWord), assert wdPop on each emitted slot, keep a word counter, and go to RELEASE after word NWORDS-1.
REQ-024 RELEASE SHALL emit Token with data 0 and source 0 in the first free slot, then go to IDLE.
REQ-025 Read return: a cycle with RDdest==MY_ID while readPending=1 SHALL drive rdWord=RDreturn and rdWordValid=1 on the next cycle.
REQ-026 On the NWORDS-th returned word, readDone SHALL pulse together with that word's rdWordValid, and readPending SHALL clear.
REQ-027 RDdest==MY_ID while readPending=0 SHALL be ignored.
REQ-028 busy SHALL equal (state!=IDLE) | readPending.
REQ-029 Both counters SHALL be log2(NWORDS) bits wide and wrap to 0 at the end of each burst.

Reset
REQ-030 On reset the block SHALL set state=IDLE, clear counters and readPending, and drive SlotTypeOut=Null, RingOut=0, SourceOut=0, and wdPop, rdWordValid and readDone to 0.
REQ-031 Reset mid-burst SHALL abandon the burst; the token is not regenerated (ring-level reinit owns that).

Structure
REQ-032 Slot-type codes (Null, Token, Address, WriteData) and the address-word field positions SHALL live in the shared ring package.
REQ-033 The read-return collector SHALL be a sub-module named rd_return_catcher.

Verification
REQ-034 Write at 0x0001234 with the Token arriving 3 cycles later -> the slot after the Token emits Address 0x00001234, then 8 WriteData words with 8 wdPop pulses, then a Token.
REQ-035 Read at 0x3FFFFFF -> Address 0x13FFFFFF, then a Token; 8 words with RDdest=MY_ID -> 8 rdWordValid, with readDone on word 8.
REQ-036 Foreign Address slot arriving mid-SEND_DATA -> the slot passes unchanged and the word count is unaffected; the burst completes after 1 extra cycle.
REQ-037 Slot with SourceIn=MY_ID -> Null output; Token arriving while IDLE -> the Token is forwarded 1 cycle later.
REQ-038 reqValid during readPending -> reqReady=0 until readDone; RDdest=MY_ID while idle -> no rdWordValid.
REQ-039 Reset asserted at word 4 of a write -> next cycle Null outputs, state IDLE, reqReady=1.
